// File: rtl/uart_win_cmd_pkg.sv
// uart_win_cmd_pkg: shared states, protocol bytes and window range helper
package uart_win_cmd_pkg;
  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, CSUM, CHECK} state_t;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CMD_SET = 8'h01;
  localparam logic [7:0] CMD_RESTORE = 8'h02;
  // True when pos/len both fit 10 bits, len is non-zero and pos+len stays within lim
  function automatic logic span_ok(input logic [15:0] pos, input logic [15:0] len, input logic [11:0] lim);
    return pos[15:10] == 6'd0 && len[15:10] == 6'd0 && len != 16'd0 &&
           ({2'b00, pos[9:0]} + {2'b00, len[9:0]}) <= lim;
  endfunction
endpackage

// File: rtl/uart_win_cmd_timeout.sv
// uart_win_cmd_timeout: inter-byte idle watchdog with single-cycle expiry pulse
module uart_win_cmd_timeout #(
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign expired = en && !clr && cnt == '0;
  // Reload while idle, on every byte and on expiry; otherwise count down
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (!en || clr || cnt == '0) cnt <= W'(TIMEOUT_CYC - 1);
    else cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/uart_win_cmd.sv
// uart_win_cmd: framed UART window command parser with frame-aligned commit
module uart_win_cmd
  import uart_win_cmd_pkg::*;
#(
  parameter int H_MAX = 1280,
  parameter int V_MAX = 720,
  parameter int DEF_X = 0,
  parameter int DEF_Y = 0,
  parameter int DEF_W = 640,
  parameter int DEF_H = 480,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  input  logic       frame_start,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] w,
  output logic [9:0] h,
  output logic [7:0] ack_data,
  output logic       ack_flag,
  output logic       pend
);
  state_t state, state_n;
  logic [7:0] cmd, acc;
  logic [63:0] pay;
  logic [2:0] idx;
  logic csum_ok, expired, set_ok, accept;
  logic [9:0] px, py, pw, ph, nx, ny, nw, nh;

  uart_win_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(sys_clk),
    .rst(sys_rst),
    .en(state != IDLE),
    .clr(pi_flag),
    .expired(expired)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else state <= state_n;
  end

  // Next-state: bytes advance the packet, an idle gap abandons it, CHECK lasts one cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pi_flag && pi_data == HDR) state_n = CMD;
      CMD:     if (pi_flag) state_n = (pi_data == CMD_SET) ? PAYLOAD : CSUM;
               else if (expired) state_n = IDLE;
      PAYLOAD: if (pi_flag && idx == 3'd7) state_n = CSUM;
               else if (expired) state_n = IDLE;
      CSUM:    if (pi_flag) state_n = CHECK;
               else if (expired) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture cmd, shift in payload and run the XOR checksum
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd <= '0;
      acc <= '0;
      pay <= '0;
      idx <= '0;
      csum_ok <= 1'b0;
    end else if (pi_flag) begin
      case (state)
        CMD: begin
          cmd <= pi_data;
          acc <= pi_data;
          idx <= '0;
        end
        PAYLOAD: begin
          pay <= {pay[55:0], pi_data};
          acc <= acc ^ pi_data;
          idx <= idx + 3'd1;
        end
        CSUM: csum_ok <= (pi_data == acc);
        default: ;
      endcase
    end
  end

  assign set_ok = span_ok(pay[63:48], pay[31:16], 12'(H_MAX)) && span_ok(pay[47:32], pay[15:0], 12'(V_MAX));
  assign accept = state == CHECK && csum_ok && (cmd == CMD_RESTORE || (cmd == CMD_SET && set_ok));
  assign nx = (cmd == CMD_SET) ? pay[57:48] : 10'(DEF_X);
  assign ny = (cmd == CMD_SET) ? pay[41:32] : 10'(DEF_Y);
  assign nw = (cmd == CMD_SET) ? pay[25:16] : 10'(DEF_W);
  assign nh = (cmd == CMD_SET) ? pay[9:0] : 10'(DEF_H);

  // Respond once per checked packet, stage accepted windows, commit them on frame_start
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {x, y, w, h} <= {10'(DEF_X), 10'(DEF_Y), 10'(DEF_W), 10'(DEF_H)};
      {px, py, pw, ph} <= {10'(DEF_X), 10'(DEF_Y), 10'(DEF_W), 10'(DEF_H)};
      pend <= 1'b0;
      ack_flag <= 1'b0;
      ack_data <= 8'h00;
    end else begin
      ack_flag <= state == CHECK;
      if (state == CHECK) ack_data <= accept ? ACK : NAK;
      if (frame_start && pend) {x, y, w, h} <= {px, py, pw, ph};
      if (accept) {px, py, pw, ph} <= {nx, ny, nw, nh};
      pend <= accept || (pend && !frame_start);
    end
  end
endmodule

// File: tb/tb_uart_win_cmd.sv
// tb_uart_win_cmd: directed vector bench for the window command parser
module tb_uart_win_cmd;
  localparam int TO = 40;
  logic sys_clk = 1'b0, sys_rst = 1'b1, pi_flag = 1'b0, frame_start = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic [9:0] x, y, w, h;
  logic [7:0] ack_data;
  logic ack_flag, pend;
  int n_cmp = 0, n_err = 0, ack_cnt = 0;

  uart_win_cmd #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .frame_start(frame_start), .x(x), .y(y), .w(w), .h(h),
    .ack_data(ack_data), .ack_flag(ack_flag), .pend(pend)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (ack_flag) ack_cnt <= ack_cnt + 1;

  typedef struct {
    logic [7:0] cmd;
    logic [15:0] px, py, pw, ph;
    logic bad;
    logic [7:0] eack;
    logic epend;
    logic [9:0] ex, ey, ew, eh;
  } vec_t;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [87:0] mk_set(input logic [15:0] a, b, c, d, input logic bad);
    logic [7:0] cs;
    cs = 8'h01 ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ c[15:8] ^ c[7:0] ^ d[15:8] ^ d[7:0] ^ {7'd0, bad};
    return {8'hA5, 8'h01, a, b, c, d, cs};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    pi_data = b;
    pi_flag = 1'b1;
    tick();
    pi_flag = 1'b0;
  endtask

  task automatic send_pkt(input logic [87:0] p, input int n, input logic [7:0] eack, input logic epend, input logic fs_chk);
    for (int i = 0; i < n; i++) begin
      send_byte(p[87-8*i -: 8]);
      if (i != n - 1) begin tick(); tick(); end
    end
    chk("ack_early", ack_flag, 1'b0);
    frame_start = fs_chk;
    tick();
    frame_start = 1'b0;
    chk("ack_flag", ack_flag, 1'b1);
    chk("ack_data", ack_data, eack);
    chk("pend_after_ack", pend, epend);
    tick();
    chk("ack_width", ack_flag, 1'b0);
  endtask

  task automatic frame(input logic [9:0] ex, ey, ew, eh);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("pend_after_frame", pend, 1'b0);
    chk("x", x, ex);
    chk("y", y, ey);
    chk("w", w, ew);
    chk("h", h, eh);
  endtask

  vec_t v[12];

  initial begin
    int a0;
    v[0]  = '{8'h01, 16'd100, 16'd50, 16'd640, 16'd360, 1'b1, 8'h15, 1'b0, 10'd0, 10'd0, 10'd640, 10'd480};
    v[1]  = '{8'h01, 16'd100, 16'd50, 16'd640, 16'd360, 1'b0, 8'h06, 1'b1, 10'd100, 10'd50, 10'd640, 10'd360};
    v[2]  = '{8'h01, 16'd700, 16'd0, 16'd600, 16'd100, 1'b0, 8'h15, 1'b0, 10'd100, 10'd50, 10'd640, 10'd360};
    v[3]  = '{8'h01, 16'd680, 16'd0, 16'd600, 16'd720, 1'b0, 8'h06, 1'b1, 10'd680, 10'd0, 10'd600, 10'd720};
    v[4]  = '{8'h01, 16'd0, 16'd0, 16'd0, 16'd10, 1'b0, 8'h15, 1'b0, 10'd680, 10'd0, 10'd600, 10'd720};
    v[5]  = '{8'h01, 16'd0, 16'd0, 16'd10, 16'h0400, 1'b0, 8'h15, 1'b0, 10'd680, 10'd0, 10'd600, 10'd720};
    v[6]  = '{8'h01, 16'd0, 16'd1, 16'd10, 16'd720, 1'b0, 8'h15, 1'b0, 10'd680, 10'd0, 10'd600, 10'd720};
    v[7]  = '{8'h03, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 8'h15, 1'b0, 10'd680, 10'd0, 10'd600, 10'd720};
    v[8]  = '{8'h01, 16'h0400, 16'd0, 16'd1, 16'd1, 1'b0, 8'h15, 1'b0, 10'd680, 10'd0, 10'd600, 10'd720};
    v[9]  = '{8'h01, 16'd1023, 16'd719, 16'd257, 16'd1, 1'b0, 8'h06, 1'b1, 10'd1023, 10'd719, 10'd257, 10'd1};
    v[10] = '{8'h02, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 8'h15, 1'b0, 10'd1023, 10'd719, 10'd257, 10'd1};
    v[11] = '{8'h02, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 8'h06, 1'b1, 10'd0, 10'd0, 10'd640, 10'd480};
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    chk("rst_x", x, 10'd0);
    chk("rst_y", y, 10'd0);
    chk("rst_w", w, 10'd640);
    chk("rst_h", h, 10'd480);
    chk("rst_pend", pend, 1'b0);
    chk("rst_ack_flag", ack_flag, 1'b0);
    chk("rst_ack_data", ack_data, 8'h00);
    for (int i = 0; i < 12; i++) begin
      if (v[i].cmd == 8'h01)
        send_pkt(mk_set(v[i].px, v[i].py, v[i].pw, v[i].ph, v[i].bad), 11, v[i].eack, v[i].epend, 1'b0);
      else
        send_pkt({8'hA5, v[i].cmd, v[i].cmd ^ {7'd0, v[i].bad}, 64'd0}, 3, v[i].eack, v[i].epend, 1'b0);
      frame(v[i].ex, v[i].ey, v[i].ew, v[i].eh);
    end
    send_pkt(mk_set(16'd100, 16'd50, 16'd640, 16'd360, 1'b0), 11, 8'h06, 1'b1, 1'b0);
    frame(10'd100, 10'd50, 10'd640, 10'd360);
    send_pkt({8'h00, 8'h13, 8'hA5, 8'h02, 8'h02, 48'd0}, 5, 8'h06, 1'b1, 1'b0);
    frame(10'd0, 10'd0, 10'd640, 10'd480);
    a0 = ack_cnt;
    foreach (v[0].cmd[i]) if (i < 5) begin end
    send_byte(8'hA5); tick();
    send_byte(8'h01); tick();
    send_byte(8'h00); tick();
    send_byte(8'h64); tick();
    send_byte(8'h00);
    repeat (TO + 1) tick();
    chk("timeout_no_ack", ack_cnt - a0, 0);
    send_pkt(mk_set(16'd10, 16'd20, 16'd30, 16'd40, 1'b0), 11, 8'h06, 1'b1, 1'b0);
    repeat (4) tick();
    chk("timeout_ack_count", ack_cnt - a0, 1);
    frame(10'd10, 10'd20, 10'd30, 10'd40);
    send_pkt(mk_set(16'd1, 16'd2, 16'd3, 16'd4, 1'b0), 11, 8'h06, 1'b1, 1'b0);
    send_pkt(mk_set(16'd5, 16'd6, 16'd7, 16'd8, 1'b0), 11, 8'h06, 1'b1, 1'b1);
    chk("coinc_x", x, 10'd1);
    chk("coinc_y", y, 10'd2);
    chk("coinc_w", w, 10'd3);
    chk("coinc_h", h, 10'd4);
    frame(10'd5, 10'd6, 10'd7, 10'd8);
    a0 = ack_cnt;
    send_byte(8'hA5); tick();
    send_byte(8'h02);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    send_byte(8'h02);
    repeat (5) tick();
    chk("rst_mid_no_ack", ack_cnt - a0, 0);
    chk("rst_mid_x", x, 10'd0);
    chk("rst_mid_w", w, 10'd640);
    chk("rst_mid_pend", pend, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
